// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and 50 MHz defaults.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // 20 ms at 50 MHz
    localparam int DEFAULT_STABLE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_WIDTH     = 20;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for one asynchronous board input; reusable for every switch/key.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Clr,
    input  logic D,
    output logic Q
);

    logic ff1_reg;
    logic ff2_reg;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            ff1_reg <= RESET_VAL;
            ff2_reg <= RESET_VAL;
        end else begin
            ff1_reg <= D;
            ff2_reg <= ff1_reg;
        end
    end

    assign Q = ff2_reg;

endmodule

// File: rtl/button_debouncer.sv
// Synchronised, counter-filtered debouncer: clean Level plus one-cycle Rise/Fall strobes.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic Clk,
    input  logic Clr,
    input  logic Raw,
    output logic Level,
    output logic Rise,
    output logic Fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync_q;
    logic                 s;
    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 level_reg, level_next;
    logic                 rise_reg, rise_next;
    logic                 fall_reg, fall_next;

    // Flops reset to the raw inactive level so the sample starts at 0 for either polarity.
    sync_2ff #(
        .RESET_VAL(ACTIVE_LOW)
    ) u_sync (
        .Clk(Clk),
        .Clr(Clr),
        .D  (Raw),
        .Q  (sync_q)
    );

    assign s = sync_q ^ ACTIVE_LOW;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            IDLE_LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next = IDLE_HIGH;
                        cnt_next   = '0;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = WAIT_HIGH;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next = IDLE_LOW;
                        cnt_next   = '0;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = WAIT_LOW;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_reg <= IDLE_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign Level = level_reg;
    assign Rise  = rise_reg;
    assign Fall  = fall_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, both input polarities.
module tb_button_debouncer;

    localparam int SC = 4;
    localparam int CW = 3;

    logic clk    = 1'b0;
    logic clr    = 1'b1;
    logic raw    = 1'b1;
    logic clr_al = 1'b1;
    logic raw_al = 1'b1;
    logic level, rise, fall;
    logic level_al, rise_al, fall_al;

    int checks = 0;
    int errors = 0;

    logic pat [0:7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES(SC),
        .CNT_WIDTH    (CW),
        .ACTIVE_LOW   (1'b0)
    ) dut (
        .Clk  (clk),
        .Clr  (clr),
        .Raw  (raw),
        .Level(level),
        .Rise (rise),
        .Fall (fall)
    );

    button_debouncer #(
        .STABLE_CYCLES(SC),
        .CNT_WIDTH    (CW),
        .ACTIVE_LOW   (1'b1)
    ) dut_al (
        .Clk  (clk),
        .Clr  (clr_al),
        .Raw  (raw_al),
        .Level(level_al),
        .Rise (rise_al),
        .Fall (fall_al)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0b exp %0b", tag, got, exp);
        end else begin
            $display("ok   %s = %0b", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic l, input logic r, input logic f);
        check({tag, ".level"}, level, l);
        check({tag, ".rise"},  rise,  r);
        check({tag, ".fall"},  fall,  f);
    endtask

    task automatic chk3_al(input string tag, input logic l, input logic r, input logic f);
        check({tag, ".level"}, level_al, l);
        check({tag, ".rise"},  rise_al,  r);
        check({tag, ".fall"},  fall_al,  f);
    endtask

    initial begin
        // 1: reset with Raw active, then release
        for (int i = 0; i < 3; i++) begin
            step();
            chk3($sformatf("t1_rst%0d", i), 1'b0, 1'b0, 1'b0);
        end
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk3($sformatf("t1_e%0d", i), 1'b0, 1'b0, 1'b0);
        end
        step();
        chk3("t1_e5", 1'b1, 1'b1, 1'b0);
        step();
        chk3("t1_e6", 1'b1, 1'b0, 1'b0);

        // 4: low 3, high 1, then low held
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk3($sformatf("t4_e%0d", i), 1'b1, 1'b0, 1'b0);
        end
        raw = 1'b1;
        step();
        chk3("t4_e3", 1'b1, 1'b0, 1'b0);
        raw = 1'b0;
        for (int i = 4; i < 9; i++) begin
            step();
            chk3($sformatf("t4_e%0d", i), 1'b1, 1'b0, 1'b0);
        end
        step();
        chk3("t4_e9", 1'b0, 1'b0, 1'b1);
        step();
        chk3("t4_e10", 1'b0, 1'b0, 1'b0);

        // 2: clean 0->1
        raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk3($sformatf("t2_e%0d", i), 1'b0, 1'b0, 1'b0);
        end
        step();
        chk3("t2_e5", 1'b1, 1'b1, 1'b0);
        step();
        chk3("t2_e6", 1'b1, 1'b0, 1'b0);

        raw = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk3("t2_back_low", 1'b0, 1'b0, 1'b0);

        // 3: short high pulses of 1, 2, 3 cycles
        for (int i = 0; i < 14; i++) begin
            raw = (i < 8) ? pat[i] : 1'b0;
            step();
            chk3($sformatf("t3_c%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // 5: reset while waiting at cnt=3
        raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk3($sformatf("t5_e%0d", i), 1'b0, 1'b0, 1'b0);
        end
        check("t5_cnt_pre", dut.cnt_reg == 3'd3, 1'b1);
        clr = 1'b1;
        #1;
        chk3("t5_clr", 1'b0, 1'b0, 1'b0);
        check("t5_cnt_clr", dut.cnt_reg == 3'd0, 1'b1);
        step();
        chk3("t5_held", 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk3($sformatf("t5_r%0d", i), 1'b0, 1'b0, 1'b0);
        end
        step();
        chk3("t5_r5", 1'b1, 1'b1, 1'b0);

        // 6: active-low instance
        chk3_al("t6_rst", 1'b0, 1'b0, 1'b0);
        raw_al = 1'b0;
        clr_al = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk3_al($sformatf("t6_e%0d", i), 1'b0, 1'b0, 1'b0);
        end
        step();
        chk3_al("t6_e5", 1'b1, 1'b1, 1'b0);
        step();
        chk3_al("t6_e6", 1'b1, 1'b0, 1'b0);
        raw_al = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk3_al($sformatf("t6_f%0d", i), 1'b1, 1'b0, 1'b0);
        end
        step();
        chk3_al("t6_f5", 1'b0, 1'b0, 1'b1);
        step();
        chk3_al("t6_f6", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
